current_bank_accum: RTL and testbench

//   Parametrised double-buffered synaptic current store for the Izhikevich neuron array.

---
 rtl/izh_pkg.sv | 46 ++++
 rtl/current_sat_add.sv | 43 ++++
 rtl/current_bank_accum.sv | 150 +++++++++++++++
 tb/tb_current_bank_accum.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/izh_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : izh_pkg
//  Purpose  : Shared types and helpers for the Izhikevich neuron array
//             current path: default current width, signed current type,
//             bank-store FSM state encoding and a saturating adder.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package izh_pkg;

  localparam int CURRENT_W = 17;

  typedef logic signed [CURRENT_W-1:0] current_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  typedef struct packed {
    current_t sum;
    logic     ovf;
  } sat_result_t;

  // Add two currents at CURRENT_W+1 bits. When sat_en is set and the true
  // sum does not fit, clamp to the most positive / most negative value and
  // flag it; otherwise the low CURRENT_W bits are returned (modulo wrap).
  function automatic sat_result_t sat_add(input current_t a,
                                          input current_t b,
                                          input logic     sat_en);
    logic signed [CURRENT_W:0] w_wide;
    sat_result_t               r;
    w_wide = {a[CURRENT_W-1], a} + {b[CURRENT_W-1], b};
    r.ovf  = sat_en & (w_wide[CURRENT_W] ^ w_wide[CURRENT_W-1]);
    if (r.ovf) begin
      r.sum = w_wide[CURRENT_W] ? {1'b1, {(CURRENT_W-1){1'b0}}}
                                : {1'b0, {(CURRENT_W-1){1'b1}}};
    end else begin
      r.sum = w_wide[CURRENT_W-1:0];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/current_sat_add.sv
`default_nettype none
// ============================================================================
//  Module   : current_sat_add
//  Purpose  : Combinational WIDTH-bit signed adder with optional clamping.
//  Ports    : a, b  in  WIDTH  signed operands
//             sum   out WIDTH  wrapped or clamped sum
//             ovf   out 1      set when a clamp was applied (0 if SAT_EN=0)
//  Revision : 1.0  initial release
// ============================================================================
module current_sat_add
  import izh_pkg::*;
#(
  parameter int WIDTH  = CURRENT_W,
  parameter bit SAT_EN = 1'b0
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] sum,
  output logic                    ovf
);

  generate
    if (WIDTH == CURRENT_W) begin : g_pkg_add
      // Native current width: reuse the shared package helper.
      sat_result_t w_res;
      assign w_res = sat_add(current_t'(a), current_t'(b), SAT_EN);
      assign sum   = w_res.sum;
      assign ovf   = w_res.ovf;
    end else begin : g_generic_add
      logic signed [WIDTH:0] w_wide;
      logic                  w_sign_mismatch;
      assign w_wide          = {a[WIDTH-1], a} + {b[WIDTH-1], b};
      // Top two bits differ exactly when the sum left the WIDTH-bit range.
      assign w_sign_mismatch = w_wide[WIDTH] ^ w_wide[WIDTH-1];
      assign ovf             = SAT_EN & w_sign_mismatch;
      assign sum             = ovf ? (w_wide[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                    : {1'b0, {(WIDTH-1){1'b1}}})
                                   : w_wide[WIDTH-1:0];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/current_bank_accum.sv
`default_nettype none
// ============================================================================
//  Module   : current_bank_accum
//  Purpose  : Double-buffered synaptic current store. Bank I is read by the
//             neuron update; bank I_next is written/accumulated by spike
//             delivery. A swap exchanges the banks, then a DEPTH-cycle sweep
//             zeroes the new I_next.
//  Config   : define ICU_SATURATE_EN to clamp accumulations and drive the
//             sticky overflow flag; otherwise accumulation wraps and
//             overflow stays 0.
//  Ports    : clk, asyn_reset            clock, async active-high reset
//             swap / swap_ready          bank exchange handshake
//             i_next_write_*             write/accumulate into I_next
//             write_ready                writes accepted while high
//             i_read_tag/value           I bank read, 1-cycle latency
//             i_next_read_tag/value      I_next bank read, 1-cycle latency
//             overflow                   sticky saturation flag
//  Revision : 1.0  initial release
// ============================================================================
module current_bank_accum
  import izh_pkg::*;
#(
  parameter  int WIDTH = CURRENT_W,
  parameter  int DEPTH = 16,
  localparam int TAG_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    asyn_reset,
  input  logic                    swap,
  output logic                    swap_ready,
  input  logic                    i_next_write_en,
  input  logic                    i_next_write_mode,
  input  logic [TAG_W-1:0]        i_next_write_tag,
  input  logic signed [WIDTH-1:0] i_next_write_value,
  output logic                    write_ready,
  input  logic [TAG_W-1:0]        i_read_tag,
  output logic signed [WIDTH-1:0] i_read_value,
  input  logic [TAG_W-1:0]        i_next_read_tag,
  output logic signed [WIDTH-1:0] i_next_read_value,
  output logic                    overflow
);

`ifdef ICU_SATURATE_EN
  localparam bit c_SAT_EN = 1'b1;
`else
  localparam bit c_SAT_EN = 1'b0;
`endif

  localparam logic [TAG_W-1:0] c_LAST_PTR = TAG_W'(DEPTH - 1);

  // r_bank[r_bank_sel] is I, r_bank[~r_bank_sel] is I_next.
  logic signed [WIDTH-1:0] r_bank [2][DEPTH];
  logic                    r_bank_sel;
  state_t                  r_state;
  logic [TAG_W-1:0]        r_clr_ptr;
  logic                    r_overflow;

  logic                    w_next_sel;
  logic                    w_idle;
  logic                    w_wr_in_range;
  logic                    w_rd_in_range;
  logic                    w_nrd_in_range;
  logic                    w_wr_accept;
  logic signed [WIDTH-1:0] w_acc_old;
  logic signed [WIDTH-1:0] w_add_sum;
  logic                    w_add_ovf;
  logic signed [WIDTH-1:0] w_wr_data;

  assign w_next_sel     = ~r_bank_sel;
  assign w_idle         = (r_state == IDLE);
  assign w_wr_in_range  = (int'(i_next_write_tag) < DEPTH);
  assign w_rd_in_range  = (int'(i_read_tag) < DEPTH);
  assign w_nrd_in_range = (int'(i_next_read_tag) < DEPTH);
  assign w_wr_accept    = w_idle & i_next_write_en & w_wr_in_range;

  assign w_acc_old = w_wr_in_range ? r_bank[w_next_sel][i_next_write_tag] : '0;

  current_sat_add #(
    .WIDTH  (WIDTH),
    .SAT_EN (c_SAT_EN)
  ) u_sat_add (
    .a   (w_acc_old),
    .b   (i_next_write_value),
    .sum (w_add_sum),
    .ovf (w_add_ovf)
  );

  assign w_wr_data = i_next_write_mode ? w_add_sum : i_next_write_value;

  assign swap_ready  = w_idle;
  assign write_ready = w_idle;
  assign overflow    = r_overflow;

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int e = 0; e < DEPTH; e++) begin
          r_bank[b][e] <= '0;
        end
      end
      r_bank_sel        <= 1'b0;
      r_state           <= IDLE;
      r_clr_ptr         <= '0;
      r_overflow        <= 1'b0;
      i_read_value      <= '0;
      i_next_read_value <= '0;
    end else begin
      // Reads sample the arrays before this edge's write/swap/clear.
      i_read_value <= w_rd_in_range ? r_bank[r_bank_sel][i_read_tag] : '0;
      // During the sweep every I_next entry is either cleared or about to
      // be, so the whole bank reads as zero.
      i_next_read_value <= (w_idle && w_nrd_in_range)
                           ? r_bank[w_next_sel][i_next_read_tag] : '0;

      case (r_state)
        IDLE: begin
          // The write lands in the current I_next even when a swap is
          // accepted on the same edge, so it ends up in the new I.
          if (w_wr_accept) begin
            r_bank[w_next_sel][i_next_write_tag] <= w_wr_data;
          end
          if (w_wr_accept && i_next_write_mode && w_add_ovf) begin
            r_overflow <= 1'b1;
          end
          // Swap clears overflow last, so it wins over a same-cycle clamp.
          if (swap) begin
            r_bank_sel <= ~r_bank_sel;
            r_clr_ptr  <= '0;
            r_overflow <= 1'b0;
            r_state    <= CLEAR;
          end
        end
        CLEAR: begin
          r_bank[w_next_sel][r_clr_ptr] <= '0;
          if (r_clr_ptr == c_LAST_PTR) begin
            r_clr_ptr <= '0;
            r_state   <= IDLE;
          end else begin
            r_clr_ptr <= r_clr_ptr + TAG_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_current_bank_accum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_current_bank_accum
//  Purpose  : Scoreboard bench for current_bank_accum. A driver issues one
//             transaction per cycle and pushes the expected outputs computed
//             by a bank-level reference model; a monitor pops and compares.
//  Revision : 1.0  initial release
// ============================================================================
module tb_current_bank_accum;

  localparam int WIDTH = 17;
  localparam int DEPTH = 16;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             asyn_reset = 1'b0;
  logic             swap = 1'b0;
  logic             swap_ready;
  logic             i_next_write_en = 1'b0;
  logic             i_next_write_mode = 1'b0;
  logic [TAG_W-1:0] i_next_write_tag = '0;
  logic [WIDTH-1:0] i_next_write_value = '0;
  logic             write_ready;
  logic [TAG_W-1:0] i_read_tag = '0;
  logic [WIDTH-1:0] i_read_value;
  logic [TAG_W-1:0] i_next_read_tag = '0;
  logic [WIDTH-1:0] i_next_read_value;
  logic             overflow;

  always #5 clk = ~clk;

  current_bank_accum #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk                (clk),
    .asyn_reset         (asyn_reset),
    .swap               (swap),
    .swap_ready         (swap_ready),
    .i_next_write_en    (i_next_write_en),
    .i_next_write_mode  (i_next_write_mode),
    .i_next_write_tag   (i_next_write_tag),
    .i_next_write_value (i_next_write_value),
    .write_ready        (write_ready),
    .i_read_tag         (i_read_tag),
    .i_read_value       (i_read_value),
    .i_next_read_tag    (i_next_read_tag),
    .i_next_read_value  (i_next_read_value),
    .overflow           (overflow)
  );

  typedef struct {
    logic [WIDTH-1:0] rd;
    logic [WIDTH-1:0] nrd;
    logic             rdy;
    logic             ovf;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: the two banks as plain arrays plus a sweep countdown.
  logic [WIDTH-1:0] m_cur [DEPTH];
  logic [WIDTH-1:0] m_nxt [DEPTH];
  int               m_clear_left;
  bit               m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_cur[i] = '0;
      m_nxt[i] = '0;
    end
    m_clear_left = 0;
    m_ovf        = 1'b0;
  endtask

  function automatic logic [WIDTH-1:0] acc_model(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 output bit clamped);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    clamped = 1'b0;
`ifdef ICU_SATURATE_EN
    if (s > 65535) begin
      s = 65535;
      clamped = 1'b1;
    end else if (s < -65536) begin
      s = -65536;
      clamped = 1'b1;
    end
`endif
    return s[WIDTH-1:0];
  endfunction

  task automatic drive_idle();
    swap            = 1'b0;
    i_next_write_en = 1'b0;
  endtask

  task automatic step(input bit sw, input bit we, input bit md,
                      input logic [TAG_W-1:0] tg, input logic [WIDTH-1:0] val,
                      input logic [TAG_W-1:0] rt, input logic [TAG_W-1:0] nt);
    exp_t e;
    bit   cl;
    @(negedge clk);
    swap               = sw;
    i_next_write_en    = we;
    i_next_write_mode  = md;
    i_next_write_tag   = tg;
    i_next_write_value = val;
    i_read_tag         = rt;
    i_next_read_tag    = nt;
    e.rd  = m_cur[rt];
    e.nrd = (m_clear_left > 0) ? '0 : m_nxt[nt];
    if (m_clear_left == 0) begin
      if (we) begin
        if (md) begin
          m_nxt[tg] = acc_model(m_nxt[tg], val, cl);
          if (cl) m_ovf = 1'b1;
        end else begin
          m_nxt[tg] = val;
        end
      end
      if (sw) begin
        m_cur = m_nxt;
        for (int i = 0; i < DEPTH; i++) m_nxt[i] = '0;
        m_clear_left = DEPTH;
        m_ovf        = 1'b0;
      end
    end else begin
      m_clear_left--;
    end
    e.rdy = (m_clear_left == 0);
    e.ovf = m_ovf;
    exp_q.push_back(e);
  endtask

  task automatic idle_steps(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, '0, '0, TAG_W'(k), TAG_W'(k));
  endtask

  // Monitor: one registered response per issued cycle.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!asyn_reset && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("i_read_value", 32'(i_read_value), 32'(e.rd));
      check("i_next_read_value", 32'(i_next_read_value), 32'(e.nrd));
      check("swap_ready", 32'(swap_ready), 32'(e.rdy));
      check("write_ready", 32'(write_ready), 32'(e.rdy));
      check("overflow", 32'(overflow), 32'(e.ovf));
    end
  end

  initial begin
    bit               sw, we, md;
    logic [WIDTH-1:0] v;
    model_reset();
    #2 asyn_reset = 1'b1;
    #1;
    check("reset_rd", 32'(i_read_value), 32'h0);
    check("reset_nrd", 32'(i_next_read_value), 32'h0);
    check("reset_ovf", 32'(overflow), 32'h0);
    @(negedge clk);
    asyn_reset = 1'b0;
    #1;
    check("reset_swap_ready", 32'(swap_ready), 32'h1);
    check("reset_write_ready", 32'(write_ready), 32'h1);

    // Overwrite tags 0 and 1, read back from I_next.
    step(1'b0, 1'b1, 1'b0, 4'd0, 17'h08000, 4'd0, 4'd0);
    step(1'b0, 1'b1, 1'b0, 4'd1, 17'h04000, 4'd0, 4'd0);
    step(1'b0, 1'b0, 1'b0, 4'd0, 17'h00000, 4'd0, 4'd1);

    // Back-to-back accumulates on tag 3 -> 0x00180.
    step(1'b0, 1'b1, 1'b1, 4'd3, 17'h00100, 4'd0, 4'd3);
    step(1'b0, 1'b1, 1'b1, 4'd3, 17'h00100, 4'd0, 4'd3);
    step(1'b0, 1'b1, 1'b1, 4'd3, 17'h1FF80, 4'd0, 4'd3);
    step(1'b0, 1'b0, 1'b0, 4'd0, 17'h00000, 4'd3, 4'd3);

    // Swap, then hold an accumulate through the sweep: it must land once.
    step(1'b1, 1'b0, 1'b0, 4'd0, 17'h00000, 4'd3, 4'd3);
    for (int k = 0; k < DEPTH + 1; k++)
      step(1'b0, 1'b1, 1'b1, 4'd5, 17'h00010, 4'd3, TAG_W'(k));
    step(1'b0, 1'b0, 1'b0, 4'd0, 17'h00000, 4'd3, 4'd5);

    // Swap and write in the same cycle: write goes to the new I.
    step(1'b1, 1'b1, 1'b0, 4'd2, 17'h00055, 4'd2, 4'd2);
    step(1'b0, 1'b0, 1'b0, 4'd0, 17'h00000, 4'd2, 4'd2);
    idle_steps(DEPTH);
    step(1'b0, 1'b0, 1'b0, 4'd0, 17'h00000, 4'd2, 4'd2);

    // Accumulate past the positive limit, then swap to clear the flag.
    step(1'b0, 1'b1, 1'b0, 4'd7, 17'h0F000, 4'd0, 4'd7);
    step(1'b0, 1'b1, 1'b1, 4'd7, 17'h02000, 4'd0, 4'd7);
    step(1'b0, 1'b0, 1'b0, 4'd0, 17'h00000, 4'd0, 4'd7);
    step(1'b0, 1'b0, 1'b0, 4'd0, 17'h00000, 4'd0, 4'd7);
    step(1'b1, 1'b0, 1'b0, 4'd0, 17'h00000, 4'd7, 4'd7);
    step(1'b0, 1'b0, 1'b0, 4'd0, 17'h00000, 4'd7, 4'd7);

    // Reset mid-sweep: contents gone and FSM back in IDLE.
    drive_idle();
    @(posedge clk);
    #3 asyn_reset = 1'b1;
    #1;
    check("midreset_rd", 32'(i_read_value), 32'h0);
    check("midreset_nrd", 32'(i_next_read_value), 32'h0);
    check("midreset_ovf", 32'(overflow), 32'h0);
    @(negedge clk);
    asyn_reset = 1'b0;
    model_reset();
    #1;
    check("midreset_swap_ready", 32'(swap_ready), 32'h1);
    check("midreset_write_ready", 32'(write_ready), 32'h1);
    step(1'b0, 1'b0, 1'b0, 4'd0, 17'h00000, 4'd7, 4'd7);
    step(1'b0, 1'b1, 1'b0, 4'd9, 17'h01234, 4'd9, 4'd9);
    step(1'b0, 1'b0, 1'b0, 4'd0, 17'h00000, 4'd9, 4'd9);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      sw = ($urandom_range(0, 19) == 0);
      we = ($urandom_range(0, 3) != 0);
      md = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 1) != 0) v = WIDTH'($urandom);
      else v = WIDTH'($urandom_range(0, 1023)) - WIDTH'(512);
      step(sw, we, md, TAG_W'($urandom_range(0, DEPTH - 1)), v,
           TAG_W'($urandom_range(0, DEPTH - 1)), TAG_W'($urandom_range(0, DEPTH - 1)));
    end

    @(negedge clk);
    drive_idle();
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    check("scoreboard_drain", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
